// File: rtl/ptb2_arb_pkg.sv
// Shared types and constants for the ptb2 AXI4-Lite requester arbiter.
package ptb2_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_DONE
    } arb_state_t;

    localparam logic [1:0]  RESP_OKAY      = 2'b00;
    localparam logic [1:0]  RESP_SLVERR    = 2'b10;
    localparam logic [31:0] RDATA_DEADBEEF = 32'hDEADBEEF;
    localparam logic [3:0]  WSTRB_ALL      = 4'hF;

endpackage

// File: rtl/ptb2_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module ptb2_rr_picker #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        idx  = '0;
        cand = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr) + k) % N);
            if (req[cand]) idx = cand;
        end
        grant = (|req) ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/ptb2_axi4_lite_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite slave among C_NUM_REQ requesters, one transfer at a time.
// Optional watchdog: define PTB2_ARB_TIMEOUT_EN to abort stalled transfers with SLVERR.
module ptb2_axi4_lite_arbiter
    import ptb2_arb_pkg::*;
#(
    parameter int C_NUM_REQ        = 2,
    parameter int C_ADDR_WIDTH     = 32,
    parameter int C_TIMEOUT_CYCLES = 16
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    input  logic [C_NUM_REQ-1:0]              REQ_VALID,
    input  logic [C_NUM_REQ-1:0]              REQ_WE,
    input  logic [C_NUM_REQ*C_ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [C_NUM_REQ*32-1:0]           REQ_WDATA,
    output logic [C_NUM_REQ-1:0]              REQ_DONE,
    output logic [31:0]                       REQ_RDATA,
    output logic [1:0]                        REQ_RESP,
    output logic [C_ADDR_WIDTH-1:0]           M_AXI_AWADDR,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [31:0]                       M_AXI_WDATA,
    output logic [3:0]                        M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic                              M_AXI_BVALID,
    input  logic [1:0]                        M_AXI_BRESP,
    output logic                              M_AXI_BREADY,
    output logic [C_ADDR_WIDTH-1:0]           M_AXI_ARADDR,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [31:0]                       M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int IW = $clog2(C_NUM_REQ);

    arb_state_t           state;
    logic [IW-1:0]        rr_ptr;
    logic [IW-1:0]        pick_idx;
    logic [C_NUM_REQ-1:0] pick_oh;
    logic [C_NUM_REQ-1:0] gnt_oh;
    logic                 tmo_hit;

    ptb2_rr_picker #(.N(C_NUM_REQ), .IW(IW)) u_pick (
        .req   (REQ_VALID),
        .ptr   (rr_ptr),
        .grant (pick_oh),
        .idx   (pick_idx)
    );

    assign M_AXI_WSTRB = WSTRB_ALL;

`ifdef PTB2_ARB_TIMEOUT_EN
    localparam int TW = $clog2(C_TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt;
    arb_state_t    state_prev;

    // tmo_cnt holds the number of earlier cycles spent in the current state.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            tmo_cnt    <= '0;
            state_prev <= ST_IDLE;
        end else begin
            state_prev <= state;
            tmo_cnt    <= (state != state_prev) ? TW'(1) : tmo_cnt + 1'b1;
        end
    end

    assign tmo_hit = (state != ST_IDLE) && (state == state_prev) &&
                     (tmo_cnt == TW'(C_TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            gnt_oh        <= '0;
            REQ_DONE      <= '0;
            REQ_RDATA     <= '0;
            REQ_RESP      <= RESP_OKAY;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else if (tmo_hit) begin
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            REQ_RESP      <= RESP_SLVERR;
            REQ_RDATA     <= RDATA_DEADBEEF;
            REQ_DONE      <= gnt_oh;
            state         <= ST_DONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|REQ_VALID) begin
                        gnt_oh <= pick_oh;
                        rr_ptr <= IW'((int'(pick_idx) + 1) % C_NUM_REQ);
                        if (REQ_WE[pick_idx]) begin
                            M_AXI_AWADDR  <= REQ_ADDR[int'(pick_idx)*C_ADDR_WIDTH +: C_ADDR_WIDTH];
                            M_AXI_WDATA   <= REQ_WDATA[int'(pick_idx)*32 +: 32];
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            state         <= ST_WR_ADDR;
                        end else begin
                            M_AXI_ARADDR  <= REQ_ADDR[int'(pick_idx)*C_ADDR_WIDTH +: C_ADDR_WIDTH];
                            M_AXI_ARVALID <= 1'b1;
                            state         <= ST_RD_ADDR;
                        end
                    end
                end
                // AW and W retire independently; leave once neither is still pending.
                ST_WR_ADDR: begin
                    if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                    if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
                    if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY)) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        REQ_RESP     <= M_AXI_BRESP;
                        REQ_RDATA    <= '0;
                        REQ_DONE     <= gnt_oh;
                        state        <= ST_DONE;
                    end
                end
                ST_RD_ADDR: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY <= 1'b0;
                        REQ_RESP     <= M_AXI_RRESP;
                        REQ_RDATA    <= M_AXI_RDATA;
                        REQ_DONE     <= gnt_oh;
                        state        <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    REQ_DONE <= '0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ptb2_axi4_lite_arbiter.sv
// Directed self-checking bench for ptb2_axi4_lite_arbiter with a configurable AXI4-Lite slave.
module tb_ptb2_axi4_lite_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  REQ_VALID = '0, REQ_WE = '0, REQ_DONE;
    logic [63:0] REQ_ADDR = '0, REQ_WDATA = '0;
    logic [31:0] REQ_RDATA;
    logic [1:0]  REQ_RESP;
    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
    logic [31:0] M_AXI_RDATA = '0;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
    logic        M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_BVALID = 1'b0;
    logic        M_AXI_ARREADY = 1'b0, M_AXI_RVALID = 1'b0;
    logic [1:0]  M_AXI_BRESP = '0, M_AXI_RRESP = '0;

    int nchk = 0, nerr = 0;

    // slave settings, changed only while the bus is idle
    int          aw_dly = 0, w_dly = 0, ar_dly = 0;
    bit          b_never = 1'b0;
    logic [1:0]  s_bresp = 2'b00;
    logic [31:0] s_rdata = '0;

    ptb2_axi4_lite_arbiter dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .REQ_VALID(REQ_VALID), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .REQ_DONE(REQ_DONE), .REQ_RDATA(REQ_RDATA), .REQ_RESP(REQ_RESP),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BRESP(M_AXI_BRESP),
        .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for a done pulse, check who got it, then that requester drops its request.
    task automatic wait_done(input string tag, input logic [1:0] exp, output int n);
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (REQ_DONE != 2'b00) begin
                n = i;
                break;
            end
        end
        chk(tag, {62'd0, REQ_DONE}, {62'd0, exp});
        REQ_VALID = REQ_VALID & ~REQ_DONE;
    endtask

    // Slave: readies decided each cycle from the master outputs of that cycle.
    initial begin : slave
        bit got_aw = 0, got_w = 0, aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
        int aw_c = 0, w_c = 0, ar_c = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0;
                M_AXI_ARREADY = 0; M_AXI_RVALID = 0;
                got_aw = 0; got_w = 0; aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
                aw_c = 0; w_c = 0; ar_c = 0;
                continue;
            end
            if (aw_hs) got_aw = 1;
            if (w_hs)  got_w = 1;
            if (b_hs)  M_AXI_BVALID = 0;
            if (r_hs)  M_AXI_RVALID = 0;
            if (got_aw && got_w && !b_never) begin
                M_AXI_BVALID = 1; M_AXI_BRESP = s_bresp; got_aw = 0; got_w = 0;
            end
            if (ar_hs) begin
                M_AXI_RVALID = 1; M_AXI_RDATA = s_rdata; M_AXI_RRESP = 2'b00;
            end
            aw_c = M_AXI_AWVALID ? aw_c + 1 : 0;
            w_c  = M_AXI_WVALID  ? w_c + 1  : 0;
            ar_c = M_AXI_ARVALID ? ar_c + 1 : 0;
            M_AXI_AWREADY = M_AXI_AWVALID && (aw_c > aw_dly);
            M_AXI_WREADY  = M_AXI_WVALID  && (w_c > w_dly);
            M_AXI_ARREADY = M_AXI_ARVALID && (ar_c > ar_dly);
            aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
            w_hs  = M_AXI_WVALID && M_AXI_WREADY;
            b_hs  = M_AXI_BVALID && M_AXI_BREADY;
            ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
            r_hs  = M_AXI_RVALID && M_AXI_RREADY;
        end
    end

    initial begin : main
        int n, bcnt, dacc;
        // reset state
        repeat (3) tick();
        chk("rst_ctl", {59'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY}, 64'd0);
        chk("rst_done", {62'd0, REQ_DONE}, 64'd0);
        chk("rst_rdata_resp", {30'd0, REQ_RESP, REQ_RDATA}, 64'd0);
        chk("rst_addr", {M_AXI_AWADDR, M_AXI_ARADDR}, 64'd0);
        rst = 1'b0;
        tick();

        // req0 write, zero-wait slave
        REQ_WE = 2'b01; REQ_ADDR[31:0] = 32'h79C00004; REQ_WDATA[31:0] = 32'h12345678;
        REQ_VALID = 2'b01;
        tick();
        chk("t1_c1_valids", {62'd0, M_AXI_AWVALID, M_AXI_WVALID}, 64'h3);
        chk("t1_c1_aw_w", {M_AXI_AWADDR, M_AXI_WDATA}, 64'h79C00004_12345678);
        chk("t1_wstrb", {60'd0, M_AXI_WSTRB}, 64'hF);
        tick();
        chk("t1_c2_bready", {61'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 64'h1);
        tick();
        chk("t1_c3_done", {62'd0, REQ_DONE}, 64'h1);
        chk("t1_c3_resp_rdata", {30'd0, REQ_RESP, REQ_RDATA}, 64'd0);
        REQ_VALID = 2'b00;
        tick();
        chk("t1_c4_done_clear", {62'd0, REQ_DONE}, 64'd0);

        // pointer is 1: both requesting -> req1 (read) first, then req0 (write)
        REQ_WE = 2'b01; REQ_ADDR = {32'h79C00010, 32'h79C00014}; REQ_WDATA[31:0] = 32'hA5A5_0001;
        s_rdata = 32'h0BAD_F00D;
        REQ_VALID = 2'b11;
        wait_done("t2_first_grant1", 2'b10, n);
        chk("t2_rdata", {32'd0, REQ_RDATA}, {32'd0, 32'h0BAD_F00D});
        wait_done("t2_second_grant0", 2'b01, n);
        chk("t2_gap", n, 4);
        chk("t2_wr_rdata_zero", {30'd0, REQ_RESP, REQ_RDATA}, 64'd0);
        tick();

        // req1 read, ARREADY delayed 3 cycles; request dropped mid-transfer
        ar_dly = 3; s_rdata = 32'hCAFEF00D;
        REQ_WE = 2'b00; REQ_ADDR[63:32] = 32'h79C00008;
        REQ_VALID = 2'b10;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("t3_ar_hold%0d", i), {31'd0, M_AXI_ARVALID, M_AXI_ARADDR}, {31'd0, 1'b1, 32'h79C00008});
            if (i == 2) REQ_VALID = 2'b00;
        end
        tick();
        chk("t3_c5_rready", {62'd0, M_AXI_ARVALID, M_AXI_RREADY}, 64'h1);
        tick();
        chk("t3_c6_done", {62'd0, REQ_DONE}, 64'h2);
        chk("t3_c6_rdata", {30'd0, REQ_RESP, REQ_RDATA}, {32'd0, 32'hCAFEF00D});
        tick();
        ar_dly = 0;

        // write: WREADY two cycles ahead of AWREADY, slave returns SLVERR
        aw_dly = 2; s_bresp = 2'b10; bcnt = 0;
        REQ_WE = 2'b01; REQ_ADDR[31:0] = 32'h79C00020; REQ_WDATA[31:0] = 32'h0000BEEF;
        REQ_VALID = 2'b01;
        tick(); bcnt += int'(M_AXI_BREADY);
        chk("t4_c1", {62'd0, M_AXI_AWVALID, M_AXI_WVALID}, 64'h3);
        tick(); bcnt += int'(M_AXI_BREADY);
        chk("t4_c2_w_first", {62'd0, M_AXI_AWVALID, M_AXI_WVALID}, 64'h2);
        tick(); bcnt += int'(M_AXI_BREADY);
        chk("t4_c3_aw_held", {30'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_AWADDR}, {30'd0, 2'b10, 32'h79C00020});
        tick(); bcnt += int'(M_AXI_BREADY);
        chk("t4_c4_bready", {61'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 64'h1);
        tick(); bcnt += int'(M_AXI_BREADY);
        chk("t4_c5_done", {62'd0, REQ_DONE}, 64'h1);
        chk("t4_c5_resp", {30'd0, REQ_RESP, REQ_RDATA}, {30'd0, 2'b10, 32'd0});
        REQ_VALID = 2'b00;
        repeat (3) begin tick(); bcnt += int'(M_AXI_BREADY); end
        chk("t4_one_bready_phase", bcnt, 1);
        aw_dly = 0; s_bresp = 2'b00;

        // reset while waiting in WR_RESP (pointer currently 1 -> req1 granted)
        b_never = 1'b1;
        REQ_WE = 2'b10; REQ_ADDR[63:32] = 32'h79C00030; REQ_WDATA[63:32] = 32'h55AA55AA;
        REQ_VALID = 2'b10;
        tick(); tick();
        chk("t5_c2_bready", {63'd0, M_AXI_BREADY}, 64'h1);
        rst = 1'b1; REQ_VALID = 2'b00;
        tick();
        chk("t5_rst_ctl", {59'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY}, 64'd0);
        chk("t5_rst_out", {REQ_DONE, REQ_RESP, 28'd0, REQ_RDATA}, 64'd0);
        chk("t5_rst_addr", {M_AXI_AWADDR, M_AXI_WDATA}, 64'd0);
        rst = 1'b0; b_never = 1'b0; dacc = 0;
        repeat (4) begin tick(); dacc |= int'(REQ_DONE); end
        chk("t5_no_done", dacc, 0);

        // pointer back to 0 after reset: grants 0 then 1
        REQ_WE = 2'b11; REQ_ADDR = {32'h79C00044, 32'h79C00040}; REQ_WDATA = {32'h2222_2222, 32'h1111_1111};
        REQ_VALID = 2'b11;
        wait_done("t6_first_grant0", 2'b01, n);
        chk("t6_first_latency", n, 3);
        wait_done("t6_second_grant1", 2'b10, n);
        chk("t6_gap", n, 4);
        tick();

        // slave never answers B
        b_never = 1'b1;
        REQ_WE = 2'b01; REQ_ADDR[31:0] = 32'h79C00050; REQ_WDATA[31:0] = 32'h0;
        REQ_VALID = 2'b01;
`ifdef PTB2_ARB_TIMEOUT_EN
        wait_done("t7_tmo_done", 2'b01, n);
        chk("t7_tmo_cycle", n, 18);
        chk("t7_tmo_resp", {30'd0, REQ_RESP, REQ_RDATA}, {30'd0, 2'b10, 32'hDEADBEEF});
        chk("t7_tmo_bready", {63'd0, M_AXI_BREADY}, 64'd0);
`else
        dacc = 0;
        repeat (30) begin tick(); dacc |= int'(REQ_DONE); end
        chk("t7_no_done", dacc, 0);
        chk("t7_bready_held", {63'd0, M_AXI_BREADY}, 64'h1);
`endif
        REQ_VALID = 2'b00; b_never = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
